// File: rtl/ase_hssi_afu_loopback.sv
// rtl/ase_hssi_afu_loopback.sv - store-and-forward HSSI AXI-S loopback; define HSSI_LOOPBACK_MAC_SWAP_EN for first-beat MAC swap
module ase_hssi_afu_loopback #(
    parameter int TDATA_WIDTH = 512,
    parameter int TUSER_WIDTH = 1,
    parameter int TKEEP_WIDTH = TDATA_WIDTH / 8,
    parameter int FIFO_DEPTH  = 64
) (
    input  logic                   clk,
    input  logic                   SoftReset,
    input  logic                   rx_tvalid,
    input  logic                   rx_tlast,
    input  logic [TDATA_WIDTH-1:0] rx_tdata,
    input  logic [TKEEP_WIDTH-1:0] rx_tkeep,
    input  logic [TUSER_WIDTH-1:0] rx_tuser,
    output logic                   tx_tvalid,
    input  logic                   tx_tready,
    output logic                   tx_tlast,
    output logic [TDATA_WIDTH-1:0] tx_tdata,
    output logic [TKEEP_WIDTH-1:0] tx_tkeep,
    output logic [TUSER_WIDTH-1:0] tx_tuser,
    input  logic                   tx_pause,
    output logic [31:0]            rx_pkt_cnt,
    output logic [31:0]            tx_pkt_cnt,
    output logic [31:0]            drop_pkt_cnt,
    output logic                   fifo_empty
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = TDATA_WIDTH + TKEEP_WIDTH + TUSER_WIDTH + 1;

    typedef enum logic {RX_ACCEPT = 1'b0, RX_DROP = 1'b1} rx_state_t;
    typedef enum logic {TX_IDLE = 1'b0, TX_SEND = 1'b1} tx_state_t;

    rx_state_t rx_state, rx_state_next;
    tx_state_t tx_state, tx_state_next;

    logic [EW-1:0]          mem [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr, commit_ptr, rd_ptr, pkts_avail;
    logic                   full, wr_en, commit, drop, rd_en, tx_done;
    logic [EW-1:0]          rd_entry;
    logic                   rd_last;
    logic [TUSER_WIDTH-1:0] rd_user;
    logic [TKEEP_WIDTH-1:0] rd_keep;
    logic [TDATA_WIDTH-1:0] rd_data;

    // wr_ptr includes uncommitted beats, so a partial packet counts against space
    assign full       = (wr_ptr - rd_ptr) == PW'(FIFO_DEPTH);
    assign fifo_empty = (wr_ptr == rd_ptr);

    assign rd_entry = mem[rd_ptr[AW-1:0]];
    assign {rd_last, rd_user, rd_keep, rd_data} = rd_entry;

    assign tx_tvalid = (tx_state == TX_SEND);
    assign tx_tlast  = rd_last;
    assign tx_tkeep  = rd_keep;
    assign tx_tuser  = rd_user;
    assign rd_en     = tx_tvalid && tx_tready;
    assign tx_done   = rd_en && rd_last;

    always_comb begin
        rx_state_next = rx_state;
        wr_en         = 1'b0;
        commit        = 1'b0;
        drop          = 1'b0;
        case (rx_state)
            RX_ACCEPT: begin
                if (rx_tvalid) begin
                    if (!full) begin
                        wr_en  = 1'b1;
                        commit = rx_tlast;
                    end else begin
                        drop = 1'b1;
                        if (!rx_tlast) rx_state_next = RX_DROP;
                    end
                end
            end
            RX_DROP: begin
                if (rx_tvalid && rx_tlast) rx_state_next = RX_ACCEPT;
            end
            default: rx_state_next = RX_ACCEPT;
        endcase
    end

    always_comb begin
        tx_state_next = tx_state;
        case (tx_state)
            TX_IDLE: begin
                if (pkts_avail != '0 && !tx_pause) tx_state_next = TX_SEND;
            end
            TX_SEND: begin
                if (tx_done && !(pkts_avail > PW'(1) && !tx_pause)) tx_state_next = TX_IDLE;
            end
            default: tx_state_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en && !SoftReset) mem[wr_ptr[AW-1:0]] <= {rx_tlast, rx_tuser, rx_tkeep, rx_tdata};
    end

    always_ff @(posedge clk) begin
        if (SoftReset) begin
            rx_state     <= RX_ACCEPT;
            tx_state     <= TX_IDLE;
            wr_ptr       <= '0;
            commit_ptr   <= '0;
            rd_ptr       <= '0;
            pkts_avail   <= '0;
            rx_pkt_cnt   <= '0;
            tx_pkt_cnt   <= '0;
            drop_pkt_cnt <= '0;
        end else begin
            rx_state <= rx_state_next;
            tx_state <= tx_state_next;
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end else if (drop) begin
                wr_ptr <= commit_ptr;
            end
            if (commit) begin
                commit_ptr <= wr_ptr + PW'(1);
                rx_pkt_cnt <= rx_pkt_cnt + 32'd1;
            end
            if (drop) drop_pkt_cnt <= drop_pkt_cnt + 32'd1;
            if (rd_en) rd_ptr <= rd_ptr + PW'(1);
            if (tx_done) tx_pkt_cnt <= tx_pkt_cnt + 32'd1;
            case ({commit, tx_done})
                2'b10:   pkts_avail <= pkts_avail + PW'(1);
                2'b01:   pkts_avail <= pkts_avail - PW'(1);
                default: pkts_avail <= pkts_avail;
            endcase
        end
    end

`ifdef HSSI_LOOPBACK_MAC_SWAP_EN
    logic sop;

    if (TDATA_WIDTH < 96) begin : g_mac_width_check
        $error("HSSI_LOOPBACK_MAC_SWAP_EN requires TDATA_WIDTH >= 96");
    end

    always_ff @(posedge clk) begin
        if (SoftReset) begin
            sop <= 1'b1;
        end else if (rd_en) begin
            sop <= rd_last;
        end
    end

    // destination MAC occupies [47:0], source MAC [95:48] on the first beat
    always_comb begin
        tx_tdata = rd_data;
        if (sop) tx_tdata[95:0] = {rd_data[47:0], rd_data[95:48]};
    end
`else
    assign tx_tdata = rd_data;
`endif

endmodule

// File: tb/tb_ase_hssi_afu_loopback.sv
// tb/tb_ase_hssi_afu_loopback.sv - scoreboard bench for ase_hssi_afu_loopback
module tb_ase_hssi_afu_loopback;
    localparam int TDW   = 128;
    localparam int TUW   = 2;
    localparam int TKW   = TDW / 8;
    localparam int DEPTH = 8;

    typedef struct packed {
        logic [TDW-1:0] data;
        logic [TKW-1:0] keep;
        logic [TUW-1:0] user;
        logic           last;
    } beat_t;
    localparam int BW = $bits(beat_t);

    logic           clk;
    logic           SoftReset;
    logic           rx_tvalid, rx_tlast;
    logic [TDW-1:0] rx_tdata;
    logic [TKW-1:0] rx_tkeep;
    logic [TUW-1:0] rx_tuser;
    logic           tx_tvalid, tx_tready, tx_tlast;
    logic [TDW-1:0] tx_tdata;
    logic [TKW-1:0] tx_tkeep;
    logic [TUW-1:0] tx_tuser;
    logic           tx_pause;
    logic [31:0]    rx_pkt_cnt, tx_pkt_cnt, drop_pkt_cnt;
    logic           fifo_empty;
    logic [BW-1:0]  tx_beat;

    int     checks = 0;
    int     errors = 0;
    int     exp_rx = 0;
    int     exp_tx = 0;
    int     exp_drop = 0;
    beat_t  sb[$];
    beat_t  pkt[$];
    beat_t  exp_b;
    logic   rand_ready;
    logic   stall_prev;
    logic [BW-1:0] snap;

    ase_hssi_afu_loopback #(
        .TDATA_WIDTH(TDW),
        .TUSER_WIDTH(TUW),
        .TKEEP_WIDTH(TKW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .SoftReset   (SoftReset),
        .rx_tvalid   (rx_tvalid),
        .rx_tlast    (rx_tlast),
        .rx_tdata    (rx_tdata),
        .rx_tkeep    (rx_tkeep),
        .rx_tuser    (rx_tuser),
        .tx_tvalid   (tx_tvalid),
        .tx_tready   (tx_tready),
        .tx_tlast    (tx_tlast),
        .tx_tdata    (tx_tdata),
        .tx_tkeep    (tx_tkeep),
        .tx_tuser    (tx_tuser),
        .tx_pause    (tx_pause),
        .rx_pkt_cnt  (rx_pkt_cnt),
        .tx_pkt_cnt  (tx_pkt_cnt),
        .drop_pkt_cnt(drop_pkt_cnt),
        .fifo_empty  (fifo_empty)
    );

    assign tx_beat = {tx_tdata, tx_tkeep, tx_tuser, tx_tlast};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic add_beat(input logic [TDW-1:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.keep = '1;
        b.user = '0;
        b.last = l;
        pkt.push_back(b);
    endtask

    task automatic fill_random(input int len);
        beat_t b;
        pkt.delete();
        for (int i = 0; i < len; i++) begin
            b.data = {$urandom, $urandom, $urandom, $urandom};
            b.keep = TKW'($urandom);
            b.user = TUW'($urandom);
            b.last = (i == len - 1);
            pkt.push_back(b);
        end
    endtask

    // Reference: an accepted packet reappears beat for beat, first beat MAC-swapped when enabled
    task automatic push_expected();
        beat_t e;
        for (int i = 0; i < pkt.size(); i++) begin
            e = pkt[i];
`ifdef HSSI_LOOPBACK_MAC_SWAP_EN
            if (i == 0) e.data[95:0] = {pkt[i].data[47:0], pkt[i].data[95:48]};
`endif
            sb.push_back(e);
        end
    endtask

    task automatic send_pkt(input bit accept, input bit gaps);
        if (accept) begin
            push_expected();
            exp_rx++;
        end else begin
            exp_drop++;
        end
        for (int i = 0; i < pkt.size(); i++) begin
            rx_tvalid = 1'b1;
            rx_tdata  = pkt[i].data;
            rx_tkeep  = pkt[i].keep;
            rx_tuser  = pkt[i].user;
            rx_tlast  = pkt[i].last;
            @(posedge clk);
            #1;
            rx_tvalid = 1'b0;
            if (gaps) repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || tx_tvalid) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain_left", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_space(input int len);
        int n;
        n = 0;
        @(negedge clk);
        while (!((sb.size() + len <= DEPTH - 1) || sb.size() == 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("space_wait", sb.size() + len <= DEPTH - 1 || sb.size() == 0, 1);
        @(posedge clk);
        #1;
    endtask

    // with tready held low from an empty FIFO, nothing is read, so stored = committed beats
    function automatic bit fits(input int len);
        return (sb.size() + len) <= DEPTH;
    endfunction

    task automatic check_counters(input string tag);
        check({tag, "_rx_pkt_cnt"}, rx_pkt_cnt, exp_rx);
        check({tag, "_tx_pkt_cnt"}, tx_pkt_cnt, exp_tx);
        check({tag, "_drop_pkt_cnt"}, drop_pkt_cnt, exp_drop);
    endtask

    initial begin
        stall_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (SoftReset !== 1'b0) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) check("stall_hold", {tx_tvalid, tx_beat}, {1'b1, snap});
                if (tx_tvalid && tx_tready) begin
                    if (sb.size() == 0) begin
                        check("tx_unexpected_beat", tx_tvalid, 0);
                    end else begin
                        exp_b = sb.pop_front();
                        check("tx_beat", tx_beat, exp_b);
                        if (exp_b.last) exp_tx++;
                    end
                end
                stall_prev = tx_tvalid && !tx_tready;
                snap       = tx_beat;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rand_ready) tx_tready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int len;
        logic [TDW-1:0] mac_d;

        SoftReset  = 1'b1;
        rx_tvalid  = 1'b0;
        rx_tlast   = 1'b0;
        rx_tdata   = '0;
        rx_tkeep   = '0;
        rx_tuser   = '0;
        tx_tready  = 1'b1;
        tx_pause   = 1'b0;
        rand_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        SoftReset = 1'b0;
        @(negedge clk);
        check("rst_tx_tvalid", tx_tvalid, 0);
        check("rst_fifo_empty", fifo_empty, 1);
        check_counters("rst");
        @(posedge clk);
        #1;

        // directed 3-beat packet and latency
        pkt.delete();
        add_beat(TDW'(8'h11), 1'b0);
        add_beat(TDW'(8'h22), 1'b0);
        add_beat(TDW'(8'h33), 1'b1);
        send_pkt(1'b1, 1'b0);
        @(negedge clk);
        check("latency_edge_n", tx_tvalid, 0);
        @(negedge clk);
        check("latency_edge_n1", tx_tvalid, 1);
        wait_drain();
        @(negedge clk);
        check_counters("single");
        check("single_fifo_empty", fifo_empty, 1);
        @(posedge clk);
        #1;

        // ten random packets under random backpressure
        rand_ready = 1'b1;
        for (int p = 0; p < 10; p++) begin
            len = $urandom_range(1, 8);
            wait_space(len);
            fill_random(len);
            send_pkt(1'b1, 1'b1);
        end
        wait_drain();
        rand_ready = 1'b0;
        tx_tready  = 1'b1;
        @(negedge clk);
        check_counters("random");
        check("random_tx_total", tx_pkt_cnt, 11);
        @(posedge clk);
        #1;

        // overflow: 6 beats fit, 4 more do not
        tx_tready = 1'b0;
        fill_random(6);
        send_pkt(fits(6), 1'b0);
        fill_random(4);
        send_pkt(fits(4), 1'b0);
        @(negedge clk);
        check_counters("overflow");
        @(posedge clk);
        #1;
        tx_tready = 1'b1;
        wait_drain();

        // oversize packet is dropped, following packet recovers
        tx_tready = 1'b0;
        fill_random(9);
        send_pkt(fits(9), 1'b0);
        fill_random(2);
        send_pkt(fits(2), 1'b0);
        @(negedge clk);
        check_counters("oversize");
        @(posedge clk);
        #1;
        tx_tready = 1'b1;
        wait_drain();
        @(negedge clk);
        check("oversize_fifo_empty", fifo_empty, 1);
        @(posedge clk);
        #1;

        // pause raised mid-packet with a second packet queued
        tx_tready = 1'b0;
        fill_random(4);
        send_pkt(1'b1, 1'b0);
        fill_random(3);
        send_pkt(1'b1, 1'b0);
        @(posedge clk);
        #1;
        tx_tready = 1'b1;
        @(posedge clk);
        #1;
        tx_pause = 1'b1;
        n = 0;
        while (sb.size() > 3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("pause_first_done", sb.size(), 3);
        @(posedge clk);
        #1;
        repeat (4) begin
            @(negedge clk);
            check("pause_hold_idle", tx_tvalid, 0);
        end
        @(posedge clk);
        #1;
        tx_pause = 1'b0;
        @(negedge clk);
        check("pause_release_wait", tx_tvalid, 0);
        @(negedge clk);
        check("pause_release_start", tx_tvalid, 1);
        wait_drain();
        @(negedge clk);
        check_counters("pause");
        @(posedge clk);
        #1;

        // reset during beat 2 of a 4-beat transmit
        tx_tready = 1'b0;
        fill_random(4);
        send_pkt(1'b1, 1'b0);
        @(posedge clk);
        #1;
        tx_tready = 1'b1;
        @(posedge clk);
        #1;
        SoftReset = 1'b1;
        sb.delete();
        exp_rx    = 0;
        exp_tx    = 0;
        exp_drop  = 0;
        rx_tvalid = 1'b1;
        rx_tlast  = 1'b1;
        rx_tdata  = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk);
        @(negedge clk);
        check("midrst_tx_tvalid", tx_tvalid, 0);
        check("midrst_fifo_empty", fifo_empty, 1);
        check_counters("midrst");
        @(posedge clk);
        #1;
        SoftReset = 1'b0;
        rx_tvalid = 1'b0;
        rx_tlast  = 1'b0;
        @(negedge clk);
        check("postrst_fifo_empty", fifo_empty, 1);
        check("postrst_rx_pkt_cnt", rx_pkt_cnt, 0);
        @(posedge clk);
        #1;
        fill_random(2);
        send_pkt(1'b1, 1'b0);
        wait_drain();
        @(negedge clk);
        check_counters("postrst");
        @(posedge clk);
        #1;

        // MAC field pattern on the first beat
        pkt.delete();
        mac_d = {$urandom, $urandom, $urandom, $urandom};
        mac_d[95:0] = 96'hAAAAAAAAAAAA_BBBBBBBBBBBB;
        add_beat(mac_d, 1'b0);
        mac_d = {$urandom, $urandom, $urandom, $urandom};
        mac_d[95:0] = 96'hAAAAAAAAAAAA_BBBBBBBBBBBB;
        add_beat(mac_d, 1'b1);
        send_pkt(1'b1, 1'b0);
        wait_drain();
        @(negedge clk);
        check_counters("mac");
        check("final_fifo_empty", fifo_empty, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ase_hssi_afu_loopback.md
# ase_hssi_afu_loopback

AFU-side HSSI traffic responder for ASE simulation. It consumes the per-channel AXI-S RX stream driven by the HSSI emulator and buffers complete packets in a store-and-forward FIFO. It returns those packets on the per-channel AXI-S TX stream, honouring tready backpressure and link pause. It closes the loop on the emulator so host-side HSSI software can be exercised without user AFU logic.

## Interface
Parameters:
- TDATA_WIDTH, 512: tdata width in bits; must be a multiple of 8.
- TUSER_WIDTH, 1: tuser width in bits; tuser is carried through unchanged.
- TKEEP_WIDTH, TDATA_WIDTH/8: tkeep width in bits.
- FIFO_DEPTH, 64: beat capacity; must be a power of 2 and at least 4.

Ports:
- clk  in  1  interface clock.
- SoftReset  in  1  synchronous, active-high reset.
- rx_tvalid  in  1  RX beat valid. The RX side has no tready; every valid beat must be taken or dropped.
- rx_tlast  in  1  last beat of the packet.
- rx_tdata  in  TDATA_WIDTH  RX payload.
- rx_tkeep  in  TKEEP_WIDTH  RX byte enables.
- rx_tuser  in  TUSER_WIDTH  RX sideband.
- tx_tvalid  out  1  TX beat valid.
- tx_tready  in  1  sink ready.
- tx_tlast  out  1  last beat of the packet.
- tx_tdata  out  TDATA_WIDTH  TX payload.
- tx_tkeep  out  TKEEP_WIDTH  TX byte enables.
- tx_tuser  out  TUSER_WIDTH  TX sideband.
- tx_pause  in  1  link pause; blocks the start of new TX packets.
- rx_pkt_cnt  out  32  packets committed to the FIFO.
- tx_pkt_cnt  out  32  packets fully transmitted.
- drop_pkt_cnt  out  32  packets dropped.
- fifo_empty  out  1  no beats stored.

## Operation
- Storage:
  - Memory of FIFO_DEPTH entries, each entry {tlast, tuser, tkeep, tdata}.
  - Pointers are log2(FIFO_DEPTH)+1 bits wide: wr_ptr (speculative), commit_ptr, rd_ptr.
  - Full when wr_ptr - rd_ptr == FIFO_DEPTH.
  - fifo_empty = (wr_ptr == rd_ptr).
- RX FSM, state ACCEPT:
  - Valid beat and not full: write the beat and increment wr_ptr.
  - If that beat has tlast, also set commit_ptr to wr_ptr+1, increment pkts_avail and increment rx_pkt_cnt.
- RX FSM, overflow in ACCEPT:
  - Valid beat and full: restore wr_ptr to commit_ptr and increment drop_pkt_cnt.
  - Go to DROP, unless the beat has tlast, in which case stay in ACCEPT.
- RX FSM, state DROP:
  - Discard all beats.
  - On a valid tlast beat, return to ACCEPT.
- A packet longer than FIFO_DEPTH beats is always dropped.
- TX FSM, state IDLE:
  - Go to SEND when pkts_avail > 0 and !tx_pause.
- TX FSM, state SEND:
  - tx_tvalid = 1.
  - tx_* fields are read combinationally from mem[rd_ptr].
  - On tvalid && tready, increment rd_ptr.
  - On a tlast handshake, increment tx_pkt_cnt and decrement pkts_avail.
  - After a tlast handshake, stay in SEND if pkts_avail > 1 and !tx_pause; otherwise go to IDLE.
- A commit and a TX tlast handshake in the same cycle leave pkts_avail unchanged.
- A write and a read in the same cycle are both legal. The full check uses pre-cycle pointers, so the read does not free space for the same-cycle write.
- tx_pause never interrupts a packet that has already started.
- All counters wrap modulo 2^32.

## Timing
- Values after SoftReset:
  - tx_tvalid = 0, fifo_empty = 1.
  - All counters = 0, pkts_avail = 0, all pointers = 0.
  - RX FSM in ACCEPT, TX FSM in IDLE.
- tx_tdata, tx_tkeep, tx_tuser and tx_tlast are don't-care while tx_tvalid = 0.
- Latency: tlast captured at edge N → tx_tvalid high after edge N+1, given tx_pause low and TX FSM in IDLE.
- Back-to-back packets leave no idle cycle between them.
- While tx_tvalid = 1 and tx_tready = 0, all tx_* outputs hold stable.
- SoftReset asserted mid-packet:
  - Stored and partial packets are discarded.
  - tx_tvalid is 0 in the cycle after the reset edge.
  - RX beats arriving during reset are ignored.

## Configuration
- HSSI_LOOPBACK_MAC_SWAP_EN defined:
  - On the first TX beat of each packet, tx_tdata[47:0] and tx_tdata[95:48] are exchanged (destination/source MAC swap). All other bits pass unchanged.
  - A start-of-packet flag, set after reset and after each tlast handshake, marks the first beat.
  - Requires TDATA_WIDTH ≥ 96; elaboration fails otherwise.
- HSSI_LOOPBACK_MAC_SWAP_EN undefined: the TX stream is a bit-exact copy of the accepted RX packets.

## Test plan
- Single 3-beat packet, tdata 0x11/0x22/0x33, tready=1 → identical beats on TX; first beat 2 cycles after tlast capture; rx_pkt_cnt=1, tx_pkt_cnt=1, fifo_empty=1 afterwards.
- Ten random packets of 1–8 beats, tready toggled at 50% → payload, order, tkeep and tuser match; tx_* stay stable during stalls; tx_pkt_cnt=10.
- FIFO_DEPTH=8, tready=0, send a 6-beat packet then a 4-beat packet → drop_pkt_cnt=1, rx_pkt_cnt=1; after tready=1 only the 6-beat packet emerges.
- tx_pause raised mid-packet with a second packet queued → the first packet completes; the second starts the cycle after tx_pause falls.
- SoftReset during beat 2 of a 4-beat transmit → tx_tvalid=0 next cycle; all counters 0; the next 2-beat packet loops back cleanly.
- HSSI_LOOPBACK_MAC_SWAP_EN defined, first beat with bits[95:0]=0xAAAAAAAAAAAA_BBBBBBBBBBBB → TX first beat shows 0xBBBBBBBBBBBB_AAAAAAAAAAAA; later beats unchanged.
